// File: rtl/fir_csr_pkg.sv
// Shared definitions for the FIR coefficient CSR bank: register bit positions,
// commit FSM states and register-map offsets as functions of the tap count.
package fir_csr_pkg;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STAT_VALID_BIT   = 0;
  localparam int STAT_OVERRUN_BIT = 1;
  localparam int STAT_PENDING_BIT = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;

  function automatic int ctrl_ofs(input int num_taps);
    return num_taps;
  endfunction

  function automatic int status_ofs(input int num_taps);
    return num_taps + 1;
  endfunction

  function automatic int dout_ofs(input int num_taps);
    return num_taps + 2;
  endfunction

  function automatic int active_base(input int num_taps);
    return num_taps + 4;
  endfunction

endpackage

// File: rtl/fir_sample_capture.sv
// Captures filter output samples on sample_strobe and keeps sticky VALID /
// OVERRUN status; a DOUT read clears VALID, OVERRUN is write-one-to-clear.
module fir_sample_capture #(
  parameter int DOUT_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_strobe,
  input  logic [DOUT_W-1:0] dout,
  input  logic              rd_clr,
  input  logic              ovr_clr,
  output logic [DOUT_W-1:0] sample,
  output logic              valid,
  output logic              overrun
);

  logic [DOUT_W-1:0] sample_d, sample_q;
  logic              valid_d, valid_q;
  logic              overrun_d, overrun_q;
  logic              ovr_set;

  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    // A sample landing on an unread one overruns, unless that same cycle's
    // read consumes the old sample.
    ovr_set   = sample_strobe & valid_q & ~rd_clr;
    if (sample_strobe) begin
      sample_d = dout;
      valid_d  = 1'b1;
    end else if (rd_clr) begin
      valid_d  = 1'b0;
    end
    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample  = sample_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/fir_coef_csr_bank.sv
// Avalon-MM CSR slave for the FIR: shadow/active coefficient banks with an
// atomic sample-boundary commit, output sample capture and a level interrupt.
module fir_coef_csr_bank
  import fir_csr_pkg::*;
#(
  parameter int NUM_TAPS    = 8,
  parameter int COEF_W      = 8,
  parameter int DOUT_W      = 18,
  parameter int DOUT_SIGNED = 1,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DOUT_W-1:0] dout,
  input  logic              sample_strobe,
  output logic [COEF_W-1:0] coef [NUM_TAPS],
  output logic              coef_update,
  output logic              irq
);

  localparam logic [31:0] CTRL_A   = 32'(ctrl_ofs(NUM_TAPS));
  localparam logic [31:0] STATUS_A = 32'(status_ofs(NUM_TAPS));
  localparam logic [31:0] DOUT_A   = 32'(dout_ofs(NUM_TAPS));
  localparam logic [31:0] ACTIVE_A = 32'(active_base(NUM_TAPS));

  logic [COEF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEF_W-1:0] active_d [NUM_TAPS];
  logic [COEF_W-1:0] active_q [NUM_TAPS];
  commit_state_e     state_d, state_q;
  logic              coef_update_d, coef_update_q;
  logic              irq_en_d, irq_en_q;
  logic [31:0]       readdata_d, readdata_q;
  logic [31:0]       addr_w, rd_val, dout_ext;
  logic              wr_en, rd_en, commit_wr, rd_dout, ovr_w1c;
  logic [DOUT_W-1:0] sample;
  logic              valid, overrun, pending;
  logic              unused_wdata;

  assign addr_w       = 32'(address);
  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign commit_wr    = wr_en & (addr_w == CTRL_A) & writedata[CTRL_COMMIT_BIT];
  assign rd_dout      = rd_en & (addr_w == DOUT_A);
  assign ovr_w1c      = wr_en & (addr_w == STATUS_A) & writedata[STAT_OVERRUN_BIT];
  assign pending      = (state_q == PENDING);
  assign unused_wdata = ^writedata;

  fir_sample_capture #(.DOUT_W(DOUT_W)) u_capture (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .dout          (dout),
    .rd_clr        (rd_dout),
    .ovr_clr       (ovr_w1c),
    .sample        (sample),
    .valid         (valid),
    .overrun       (overrun)
  );

  // The copy reads the pre-edge shadow, so a shadow write in the copy cycle
  // only lands in the shadow bank.
  always_comb begin
    state_d       = state_q;
    coef_update_d = 1'b0;
    active_d      = active_q;
    case (state_q)
      IDLE:    if (commit_wr) state_d = PENDING;
      PENDING: if (sample_strobe) begin
        state_d       = IDLE;
        active_d      = shadow_q;
        coef_update_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_TAPS; i++)
      if (wr_en && addr_w == 32'(i)) shadow_d[i] = writedata[COEF_W-1:0];
    irq_en_d = irq_en_q;
    if (wr_en && addr_w == CTRL_A) irq_en_d = writedata[CTRL_IRQ_EN_BIT];
  end

  always_comb begin
    dout_ext = 32'(sample);
    if (DOUT_SIGNED != 0) dout_ext = 32'($signed(sample));
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (addr_w == 32'(i))            rd_val = 32'(shadow_q[i]);
      if (addr_w == ACTIVE_A + 32'(i)) rd_val = 32'(active_q[i]);
    end
    if (addr_w == CTRL_A) begin
      rd_val[CTRL_COMMIT_BIT] = pending;
      rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
    end
    if (addr_w == STATUS_A) begin
      rd_val[STAT_VALID_BIT]   = valid;
      rd_val[STAT_OVERRUN_BIT] = overrun;
      rd_val[STAT_PENDING_BIT] = pending;
    end
    if (addr_w == DOUT_A) rd_val = dout_ext;
    readdata_d = rd_en ? rd_val : readdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      state_q       <= IDLE;
      coef_update_q <= 1'b0;
      irq_en_q      <= 1'b0;
      readdata_q    <= '0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      state_q       <= state_d;
      coef_update_q <= coef_update_d;
      irq_en_q      <= irq_en_d;
      readdata_q    <= readdata_d;
    end
  end

  assign coef        = active_q;
  assign coef_update = coef_update_q;
  assign readdata    = readdata_q;
  assign irq         = irq_en_q & (valid | overrun);

endmodule
